// File: rtl/integrator_dump_sv_if.sv
// rtl/integrator_dump_sv_if.sv - sample and result signal bundle for the integrate-and-dump block
interface integrator_dump_sv_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic [7:0]            i_decim;
  logic [3:0]            i_shift;
  logic                  i_clear;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_sat;

  modport master (
    output i_data, i_valid, i_decim, i_shift, i_clear,
    input  o_data, o_valid, o_sat
  );

  modport slave (
    input  i_data, i_valid, i_decim, i_shift, i_clear,
    output o_data, o_valid, o_sat
  );
endinterface

// File: rtl/integrator_dump_sv.sv
// rtl/integrator_dump_sv.sv - block integrator with arithmetic shift and saturating dump
module integrator_dump_sv #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 8
) (
  input  logic                 i_sysclk_40,
  input  logic                 i_rst,
  integrator_dump_sv_if.slave  bus
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc;
  logic [7:0]                  cnt;
  logic [7:0]                  decim_q;
  logic [3:0]                  shift_q;

  logic [7:0]                  decim_in;
  logic [7:0]                  decim_eff;
  logic [3:0]                  shift_eff;
  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic                        last;
  logic                        clip_hi;
  logic                        clip_lo;

  // The first sample of a block uses the live decim/shift so a new setting applies immediately.
  always_comb begin
    decim_in   = (bus.i_decim == 8'd0) ? 8'd1 : bus.i_decim;
    decim_eff  = (cnt == 8'd0) ? decim_in : decim_q;
    shift_eff  = (cnt == 8'd0) ? bus.i_shift : shift_q;
    sample_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.i_data[DATA_WIDTH-1]}}, bus.i_data};
    sum        = acc + sample_ext;
    shifted    = sum >>> shift_eff;
    last       = (cnt == (decim_eff - 8'd1));
    clip_hi    = (shifted > SAT_MAX);
    clip_lo    = (shifted < SAT_MIN);
  end

  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      acc         <= '0;
      cnt         <= 8'd0;
      decim_q     <= 8'd1;
      shift_q     <= 4'd0;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
      bus.o_sat   <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      bus.o_sat   <= 1'b0;
      if (bus.i_clear) begin
        acc     <= '0;
        cnt     <= 8'd0;
        decim_q <= decim_in;
        shift_q <= bus.i_shift;
      end else if (bus.i_valid) begin
        if (cnt == 8'd0) begin
          decim_q <= decim_in;
          shift_q <= bus.i_shift;
        end
        if (last) begin
          acc         <= '0;
          cnt         <= 8'd0;
          bus.o_valid <= 1'b1;
          bus.o_sat   <= clip_hi | clip_lo;
          if (clip_hi)
            bus.o_data <= SAT_MAX[DATA_WIDTH-1:0];
          else if (clip_lo)
            bus.o_data <= SAT_MIN[DATA_WIDTH-1:0];
          else
            bus.o_data <= shifted[DATA_WIDTH-1:0];
        end else begin
          acc <= sum;
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_integrator_dump_sv.sv
// tb/tb_integrator_dump_sv.sv - vector table, long-block corners and random run against a reference model
`timescale 1ns/1ps
module tb_integrator_dump_sv;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #12.5 clk = ~clk;

  integrator_dump_sv_if #(.DATA_WIDTH(DW)) bus ();

  integrator_dump_sv #(.DATA_WIDTH(DW), .ACC_WIDTH(DW + 8)) dut (
    .i_sysclk_40 (clk),
    .i_rst       (rst),
    .bus         (bus)
  );

  typedef struct {
    logic          r;
    logic          v;
    logic [DW-1:0] d;
    logic [7:0]    dec;
    logic [3:0]    sh;
    logic          c;
    logic          ev;
    logic [DW-1:0] ed;
    logic          es;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state: samples of the open block plus the settings latched for it
  int            blk[$];
  int            m_decim = 1;
  int            m_shift = 0;
  logic          exp_v = 1'b0;
  logic [DW-1:0] exp_d = '0;
  logic          exp_s = 1'b0;

  function automatic void add(logic r, logic v, logic [DW-1:0] d, logic [7:0] dec, logic [3:0] sh,
                              logic c, logic ev, logic [DW-1:0] ed, logic es);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.dec = dec; t.sh = sh; t.c = c;
    t.ev = ev; t.ed = ed; t.es = es;
    tbl.push_back(t);
  endfunction

  function automatic void model_step(logic r, logic v, logic [DW-1:0] d, logic [7:0] dec,
                                     logic [3:0] sh, logic c);
    longint sum, p, q;
    longint lim_hi = (longint'(1) << (DW - 1)) - 1;
    longint lim_lo = -(longint'(1) << (DW - 1));
    int x;
    if (r) begin
      blk.delete(); m_decim = 1; m_shift = 0;
      exp_v = 1'b0; exp_d = '0; exp_s = 1'b0;
      return;
    end
    exp_v = 1'b0;
    exp_s = 1'b0;
    if (c) begin
      blk.delete();
      m_decim = (dec == 0) ? 1 : int'(dec);
      m_shift = int'(sh);
      return;
    end
    if (!v) return;
    if (blk.size() == 0) begin
      m_decim = (dec == 0) ? 1 : int'(dec);
      m_shift = int'(sh);
    end
    x = $signed(d);
    blk.push_back(x);
    if (blk.size() == m_decim) begin
      sum = 0;
      foreach (blk[i]) sum += blk[i];
      p = longint'(1) << m_shift;
      q = sum / p;
      if ((sum % p) != 0 && sum < 0) q -= 1;
      exp_v = 1'b1;
      if (q > lim_hi) begin exp_d = DW'(lim_hi); exp_s = 1'b1; end
      else if (q < lim_lo) begin exp_d = DW'(lim_lo); exp_s = 1'b1; end
      else exp_d = DW'(q);
      blk.delete();
    end
  endfunction

  task automatic apply(logic r, logic v, logic [DW-1:0] d, logic [7:0] dec, logic [3:0] sh, logic c);
    rst = r; bus.i_valid = v; bus.i_data = d; bus.i_decim = dec; bus.i_shift = sh; bus.i_clear = c;
    @(posedge clk);
    #1;
    model_step(r, v, d, dec, sh, c);
  endtask

  task automatic check(string name, logic ev, logic [DW-1:0] ed, logic es);
    vectors++;
    if (bus.o_valid !== ev || bus.o_data !== ed || bus.o_sat !== es) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b data=%h sat=%0b, want valid=%0b data=%h sat=%0b",
               name, bus.o_valid, bus.o_data, bus.o_sat, ev, ed, es);
    end
  endtask

  initial begin
    add(1,0,16'h0000,8'd4,4'd0,0, 0,16'h0000,0);
    add(0,1,16'h0001,8'd4,4'd0,0, 0,16'h0000,0);
    add(0,0,16'h0000,8'd4,4'd0,0, 0,16'h0000,0);
    add(0,1,16'h0002,8'd4,4'd0,0, 0,16'h0000,0);
    add(0,1,16'h0003,8'd4,4'd0,0, 0,16'h0000,0);
    add(0,0,16'h0000,8'd4,4'd0,0, 0,16'h0000,0);
    add(0,1,16'h0004,8'd4,4'd0,0, 1,16'h000A,0);
    add(0,0,16'h0000,8'd4,4'd0,0, 0,16'h000A,0);
    for (int i = 0; i < 3; i++) add(0,1,16'h7FFF,8'd4,4'd2,0, 0,16'h000A,0);
    add(0,1,16'h7FFF,8'd4,4'd2,0, 1,16'h7FFF,0);
    for (int i = 0; i < 3; i++) add(0,1,16'h7FFF,8'd4,4'd0,0, 0,16'h7FFF,0);
    add(0,1,16'h7FFF,8'd4,4'd0,0, 1,16'h7FFF,1);
    add(0,0,16'h0000,8'd4,4'd0,0, 0,16'h7FFF,0);
    add(0,1,16'h8000,8'd2,4'd0,0, 0,16'h7FFF,0);
    add(0,1,16'h8000,8'd2,4'd0,0, 1,16'h8000,1);
    add(0,1,16'hFFFD,8'd0,4'd1,0, 1,16'hFFFE,0);
    add(0,1,16'h0005,8'd1,4'd0,0, 1,16'h0005,0);
    add(0,1,16'h8000,8'd1,4'd0,0, 1,16'h8000,0);
    add(0,1,16'hFFFF,8'd1,4'd0,0, 1,16'hFFFF,0);
    add(0,1,16'h0064,8'd4,4'd0,0, 0,16'hFFFF,0);
    add(0,1,16'h0064,8'd4,4'd0,0, 0,16'hFFFF,0);
    add(0,1,16'h0064,8'd4,4'd0,1, 0,16'hFFFF,0);
    for (int i = 0; i < 3; i++) add(0,1,16'h0001,8'd4,4'd0,0, 0,16'hFFFF,0);
    add(0,1,16'h0001,8'd4,4'd0,0, 1,16'h0004,0);
    for (int i = 0; i < 3; i++) add(0,1,16'h0007,8'd4,4'd0,0, 0,16'h0004,0);
    add(1,1,16'h0007,8'd4,4'd0,0, 0,16'h0000,0);
    for (int i = 0; i < 3; i++) add(0,1,16'h0005,8'd4,4'd0,0, 0,16'h0000,0);
    add(0,1,16'h0005,8'd4,4'd0,0, 1,16'h0014,0);
    add(0,1,16'h0001,8'd4,4'd0,0, 0,16'h0014,0);
    add(0,1,16'h0001,8'd2,4'd0,0, 0,16'h0014,0);
    add(0,1,16'h0001,8'd2,4'd0,0, 0,16'h0014,0);
    add(0,1,16'h0001,8'd2,4'd0,0, 1,16'h0004,0);
    add(0,1,16'h0001,8'd2,4'd0,0, 0,16'h0004,0);
    add(0,1,16'h0001,8'd2,4'd0,0, 1,16'h0002,0);
    add(0,1,16'h0001,8'd2,4'd0,0, 0,16'h0002,0);
    add(0,1,16'h0001,8'd2,4'd0,0, 1,16'h0002,0);
    add(0,1,16'h0009,8'd1,4'd0,1, 0,16'h0002,0);
    add(0,1,16'h0009,8'd1,4'd0,0, 1,16'h0009,0);
    add(0,1,16'hFFF1,8'd1,4'd4,0, 1,16'hFFFF,0);

    apply(1, 0, '0, 8'd1, 4'd0, 0);
    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].dec, tbl[k].sh, tbl[k].c);
      check($sformatf("table[%0d]", k), tbl[k].ev, tbl[k].ed, tbl[k].es);
    end

    // longest block at full scale: accumulator must not wrap
    for (int i = 0; i < 255; i++) apply(0, 1, 16'h7FFF, 8'd255, 4'd8, 0);
    check("max_block_pos", 1'b1, 16'd32639, 1'b0);
    for (int i = 0; i < 255; i++) apply(0, 1, 16'h8000, 8'd255, 4'd8, 0);
    check("max_block_neg", 1'b1, 16'h8080, 1'b0);
    apply(0, 0, '0, 8'd255, 4'd8, 0);
    check("max_block_idle", 1'b0, 16'h8080, 1'b0);

    apply(1, 0, '0, 8'd1, 4'd0, 0);
    check("random_reset", exp_v, exp_d, exp_s);
    for (int n = 0; n < 4000; n++) begin
      logic          r, v, c;
      logic [DW-1:0] d;
      logic [7:0]    dec;
      logic [3:0]    sh;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       d = 16'h7FFF;
        1:       d = 16'h8000;
        default: d = DW'($urandom);
      endcase
      dec = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(9, 40)) : 8'($urandom_range(0, 6));
      sh  = 4'($urandom_range(0, 15));
      apply(r, v, d, dec, sh, c);
      check($sformatf("random[%0d]", n), exp_v, exp_d, exp_s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
